rc4_stream_ctrl: RTL and testbench

- Sequencer wrapped around the rc4 keystream core.
- Accepts a key command, pulses the core start, waits for key scheduling (KSA) to complete, then buffers the core's keystream bytes in a small FIFO.
- XORs buffered keystream with an incoming plaintext/ciphertext byte stream using valid/ready handshakes on both sides.
- Sits between the host-side command/data interfaces and a single rc4 core instance.

---
 rtl/rc4_stream_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rc4_stream_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_stream_ctrl.sv
// Sequencer around an rc4 keystream core: latches a key command, starts the core,
// waits out key scheduling, then XORs buffered keystream onto a handshaked byte stream.
module rc4_stream_ctrl #(
    parameter int NUMS_OF_BYTES = 16,
    parameter int KS_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [NUMS_OF_BYTES*8-1:0] cmd_key,
    input  logic [7:0]                 cmd_key_len,
    output logic                       cmd_err,
    input  logic                       abort,
    output logic                       busy,
    output logic                       core_start,
    output logic [NUMS_OF_BYTES*8-1:0] core_key,
    output logic [7:0]                 core_key_length,
    input  logic                       core_ksa_done,
    input  logic                       core_ks_valid,
    input  logic [7:0]                 core_ks_data,
    output logic                       core_ks_ready,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [7:0]                 din_data,
    input  logic                       din_last,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [7:0]                 dout_data,
    output logic                       dout_last,
    output logic [31:0]                byte_cnt
);

    localparam int         PTR_W   = $clog2(KS_DEPTH);
    localparam int         KEY_W   = NUMS_OF_BYTES * 8;
    localparam logic [7:0] MAX_LEN = 8'(NUMS_OF_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_KSA_WAIT,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [7:0]        key_len_q, key_len_d;
    logic              cmd_err_q, cmd_err_d;
    logic [31:0]       byte_cnt_q, byte_cnt_d;
    logic              dout_valid_q, dout_valid_d;
    logic [7:0]        dout_data_q, dout_data_d;
    logic              dout_last_q, dout_last_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]        fifo_mem [KS_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic streaming;
    logic push;
    logic din_hs;
    logic out_hs;
    logic bad_len;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign streaming  = (state_q == S_STREAM);

    assign core_ks_ready = streaming && !fifo_full;
    // Once the last beat sits in the output register no further input is taken.
    assign din_ready     = streaming && !fifo_empty &&
                           (!dout_valid_q || (dout_ready && !dout_last_q));

    assign push    = core_ks_valid && core_ks_ready;
    assign din_hs  = din_valid && din_ready;
    assign out_hs  = dout_valid_q && dout_ready;
    assign bad_len = (cmd_key_len == 8'd0) || (cmd_key_len > MAX_LEN);

    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign core_start      = (state_q == S_START);
    assign cmd_err         = cmd_err_q;
    assign core_key        = key_q;
    assign core_key_length = key_len_q;
    assign dout_valid      = dout_valid_q;
    assign dout_data       = dout_data_q;
    assign dout_last       = dout_last_q;
    assign byte_cnt        = byte_cnt_q;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        key_len_d    = key_len_q;
        cmd_err_d    = 1'b0;
        byte_cnt_d   = byte_cnt_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_last_d  = dout_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (out_hs) begin
            dout_valid_d = 1'b0;
            byte_cnt_d   = byte_cnt_q + 32'd1;
        end
        if (din_hs) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data ^ fifo_mem[rd_ptr_q[PTR_W-1:0]];
            dout_last_d  = din_last;
            rd_ptr_d     = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (bad_len) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        key_d      = cmd_key;
                        key_len_d  = cmd_key_len;
                        byte_cnt_d = 32'd0;
                        state_d    = S_START;
                    end
                end
            end
            S_START: state_d = S_KSA_WAIT;
            S_KSA_WAIT: begin
                if (core_ksa_done) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_hs && dout_last_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leftover keystream is discarded; the next key restarts the core.
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_FLUSH;
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            key_len_q    <= '0;
            cmd_err_q    <= 1'b0;
            byte_cnt_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_last_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            key_len_q    <= key_len_d;
            cmd_err_q    <= cmd_err_d;
            byte_cnt_q   <= byte_cnt_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_last_q  <= dout_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= core_ks_data;
        end
    end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Bench for rc4_stream_ctrl: an RC4 core model feeds keystream, and a reference
// keystream computed from scratch predicts every output beat.
module tb_rc4_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [127:0] cmd_key = '0;
    logic [7:0]   cmd_key_len = '0;
    logic         cmd_err;
    logic         abort = 1'b0;
    logic         busy;
    logic         core_start;
    logic [127:0] core_key;
    logic [7:0]   core_key_length;
    logic         core_ksa_done;
    logic         core_ks_valid;
    logic [7:0]   core_ks_data;
    logic         core_ks_ready;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [7:0]   din_data = '0;
    logic         din_last = 1'b0;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic [7:0]   dout_data;
    logic         dout_last;
    logic [31:0]  byte_cnt;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int good_cmds = 0;

    always #5 clk = ~clk;

    rc4_stream_ctrl #(.NUMS_OF_BYTES(16), .KS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_key_len(cmd_key_len), .cmd_err(cmd_err), .abort(abort), .busy(busy),
        .core_start(core_start), .core_key(core_key), .core_key_length(core_key_length),
        .core_ksa_done(core_ksa_done), .core_ks_valid(core_ks_valid),
        .core_ks_data(core_ks_data), .core_ks_ready(core_ks_ready),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .byte_cnt(byte_cnt)
    );

    // n-th RC4 keystream byte (0-based) for the given key, computed from scratch.
    function automatic logic [7:0] rc4_byte(input logic [127:0] key, input int len, input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        if (len == 0) return 8'h00;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        j = 8'd0;
        for (int k = 0; k < 256; k++) begin
            j = j + s[k] + key[(k % len) * 8 +: 8];
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k <= n; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        t = s[i] + s[j];
        return s[t];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core model: KSA takes a few cycles after start, then one byte per accepted beat.
    logic [127:0] m_key;
    logic [7:0]   m_len;
    int           m_idx;
    int           m_timer;
    logic         m_done;
    logic         ks_stall = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_key <= '0; m_len <= '0; m_idx <= 0; m_timer <= 0; m_done <= 1'b0;
        end else if (core_start) begin
            m_key <= core_key; m_len <= core_key_length; m_idx <= 0; m_timer <= 6; m_done <= 1'b0;
        end else begin
            if (m_timer > 0) m_timer <= m_timer - 1;
            if (m_timer == 1) m_done <= 1'b1;
            if (core_ks_valid && core_ks_ready) m_idx <= m_idx + 1;
        end
    end

    assign core_ksa_done = m_done;
    assign core_ks_valid = m_done && !ks_stall;
    assign core_ks_data  = rc4_byte(m_key, int'(m_len), m_idx);

    // Scoreboard of expected output beats {last, data}, plus hold-stability checks.
    logic [8:0] exp_q [$];
    logic       hold_pend = 1'b0;
    logic [8:0] hold_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (core_start) start_cnt++;
            if (hold_pend) begin
                check("hold_valid", dout_valid, 1'b1);
                check("hold_beat", {dout_last, dout_data}, hold_val);
            end
            hold_pend = dout_valid && !dout_ready;
            hold_val  = {dout_last, dout_data};
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", {dout_last, dout_data});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("dout_data", dout_data, e[7:0]);
                    check("dout_last", dout_last, e[8]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] pt_buf [64];

    task automatic load_plaintext();
        logic [71:0] s;
        s = "Plaintext";
        for (int k = 0; k < 9; k++) pt_buf[k] = s[(8 - k) * 8 +: 8];
    endtask

    task automatic expect_stream(input logic [127:0] key, input int len, input int n, input bit with_last);
        logic lb;
        for (int k = 0; k < n; k++) begin
            lb = with_last && (k == n - 1);
            exp_q.push_back({lb, pt_buf[k] ^ rc4_byte(key, len, k)});
        end
    endtask

    task automatic send_cmd(input logic [127:0] key, input logic [7:0] len);
        int t;
        bit hs;
        t = 0; hs = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_key = key; cmd_key_len = len;
        while (!hs && t < 100) begin
            @(negedge clk); hs = cmd_ready;
            @(posedge clk); #1; t++;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", hs, 1'b1);
        if (len != 8'd0 && len <= 8'd16) good_cmds++;
    endtask

    task automatic send_stream(input int n, input bit with_last);
        int t;
        bit hs;
        for (int k = 0; k < n; k++) begin
            din_valid = 1'b1; din_data = pt_buf[k]; din_last = with_last && (k == n - 1);
            t = 0; hs = 1'b0;
            while (!hs && t < 500) begin
                @(negedge clk); hs = din_ready;
                @(posedge clk); #1; t++;
            end
            if (!hs) begin
                check("din_handshake", hs, 1'b1);
                break;
            end
        end
        din_valid = 1'b0; din_last = 1'b0;
    endtask

    task automatic wait_last_then_idle(input int exp_cnt);
        int t;
        bit seen;
        t = 0; seen = 1'b0;
        while (!seen && t < 2000) begin
            @(negedge clk); seen = dout_valid && dout_ready && dout_last; t++;
        end
        check("last_seen", seen, 1'b1);
        @(negedge clk);
        check("flush_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1'b1);
        check("byte_cnt", byte_cnt, exp_cnt);
    endtask

    logic [127:0] key_k;
    logic [127:0] key16;
    logic [7:0]   rfc [9];

    initial begin
        key_k = 128'h79654B;
        for (int k = 0; k < 16; k++) key16[k * 8 +: 8] = 8'(k + 1);
        rfc = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

        // Pin the reference keystream to the published RC4 vector.
        load_plaintext();
        for (int k = 0; k < 9; k++) check("rfc_model", pt_buf[k] ^ rc4_byte(key_k, 3, k), rfc[k]);

        // Reset state.
        #22;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_outputs", {busy, cmd_err, core_start, core_ks_ready, din_ready, dout_valid, dout_last}, 7'd0);
        check("rst_core_key", {core_key, core_key_length}, 136'd0);
        check("rst_counts", {byte_cnt, dout_data}, 40'd0);
        @(negedge clk); rst_n = 1'b1;

        // Vector 1: "Key" / "Plaintext".
        expect_stream(key_k, 3, 9, 1'b1);
        send_cmd(key_k, 8'd3);
        @(negedge clk);
        check("v1_core_start", core_start, 1'b1);
        check("v1_core_key", core_key, key_k);
        check("v1_core_len", core_key_length, 8'd3);
        send_stream(9, 1'b1);
        wait_last_then_idle(9);

        // Rejected lengths 0 and 17.
        send_cmd(key16, 8'd0);
        @(negedge clk);
        check("len0_err", cmd_err, 1'b1);
        check("len0_busy", busy, 1'b0);
        @(negedge clk);
        check("len0_err_end", cmd_err, 1'b0);
        send_cmd(key16, 8'd17);
        @(negedge clk);
        check("len17_err", cmd_err, 1'b1);
        check("len17_busy", busy, 1'b0);
        check("len17_key_kept", {core_key, core_key_length}, {key_k, 8'd3});
        @(negedge clk);
        check("len17_err_end", cmd_err, 1'b0);
        check("bad_no_start", start_cnt, 1);

        // Max-length key with a 10-cycle keystream stall mid-stream.
        for (int k = 0; k < 20; k++) pt_buf[k] = 8'(k * 7 + 3);
        expect_stream(key16, 16, 20, 1'b1);
        send_cmd(key16, 8'd16);
        @(negedge clk);
        check("k16_core_len", core_key_length, 8'd16);
        fork
            send_stream(20, 1'b1);
            begin
                int t;
                t = 0;
                while (m_idx < 5 && t < 500) begin @(posedge clk); #1; t++; end
                check("stall_reached", m_idx >= 5, 1'b1);
                ks_stall = 1'b1;
                repeat (5) @(negedge clk);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_quiet", {din_ready, dout_valid}, 2'b00);
                end
                @(posedge clk); #1;
                ks_stall = 1'b0;
            end
        join
        wait_last_then_idle(20);

        // Output backpressure long enough for the FIFO to fill.
        load_plaintext();
        expect_stream(key_k, 3, 9, 1'b1);
        dout_ready = 1'b0;
        send_cmd(key_k, 8'd3);
        fork
            send_stream(9, 1'b1);
            begin
                int t;
                t = 0;
                while (!dout_valid && t < 500) begin @(negedge clk); t++; end
                check("bp_valid_seen", dout_valid, 1'b1);
                repeat (8) @(negedge clk);
                check("bp_fifo_full", core_ks_ready, 1'b0);
                check("bp_din_blocked", din_ready, 1'b0);
                check("bp_valid_held", dout_valid, 1'b1);
                @(posedge clk); #1;
                dout_ready = 1'b1;
            end
        join
        wait_last_then_idle(9);

        // Abort three bytes in, then a fresh command restarts the keystream.
        expect_stream(key_k, 3, 3, 1'b0);
        send_cmd(key_k, 8'd3);
        send_stream(3, 1'b0);
        begin
            int t;
            t = 0;
            while (!(byte_cnt == 32'd3 && !dout_valid) && t < 500) begin @(negedge clk); t++; end
        end
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_flush", {cmd_ready, busy, dout_valid, din_ready, core_ks_ready}, 5'b01000);
        @(negedge clk);
        check("abort_idle", cmd_ready, 1'b1);
        check("abort_byte_cnt", byte_cnt, 32'd3);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort_in_idle", {cmd_ready, busy}, 2'b10);
        expect_stream(key_k, 3, 9, 1'b1);
        send_cmd(key_k, 8'd3);
        send_stream(9, 1'b1);
        wait_last_then_idle(9);

        // Asynchronous reset during key scheduling.
        send_cmd(key_k, 8'd3);
        @(negedge clk);
        @(negedge clk);
        check("ksa_busy", {busy, din_ready, core_ks_ready}, 3'b100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {busy, cmd_err, core_start, core_ks_ready, din_ready, dout_valid}, 6'd0);
        check("arst_key", {core_key, core_key_length}, 136'd0);
        check("arst_byte_cnt", byte_cnt, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("arst_cmd_ready", {cmd_ready, busy}, 2'b10);
        expect_stream(key_k, 3, 9, 1'b1);
        send_cmd(key_k, 8'd3);
        send_stream(9, 1'b1);
        wait_last_then_idle(9);

        check("all_beats_seen", exp_q.size(), 0);
        check("start_pulses", start_cnt, good_cmds);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
